ltpi_data_channel_target_executor: RTL

- Consumes request words from the data channel target FIFO's request queue and executes each as one Avalon-MM master transaction on the target-side local bus.
- Pushes one response word per request into the response queue.
- Handles the FIFO's one-cycle read latency (non-showahead: q valid the cycle after rdreq), bus back-pressure, missing read data via timeout, and a full response queue.
- Processes one request at a time, in order.

---
 rtl/ltpi_data_channel_target_pkg.sv | 53 +++++
 rtl/ltpi_data_channel_target_executor.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/ltpi_data_channel_target_pkg.sv
// Shared types and word-packing offsets for the LTPI data channel target path.
// Used by the target executor, the master-side packer and the bench.
package ltpi_data_channel_target_pkg;

   localparam int ADDR_W = 16;
   localparam int DATA_W = 32;
   localparam int TAG_W  = 4;
   localparam int BE_W   = DATA_W / 8;

   // Request word, LSB first: data, addr, be, cmd, tag
   localparam int REQ_DATA_LSB = 0;
   localparam int REQ_ADDR_LSB = REQ_DATA_LSB + DATA_W;
   localparam int REQ_BE_LSB   = REQ_ADDR_LSB + ADDR_W;
   localparam int REQ_CMD_LSB  = REQ_BE_LSB + BE_W;
   localparam int REQ_TAG_LSB  = REQ_CMD_LSB + 2;
   localparam int REQ_W        = REQ_TAG_LSB + TAG_W;

   // Response word, LSB first: data, status, tag
   localparam int RESP_DATA_LSB   = 0;
   localparam int RESP_STATUS_LSB = RESP_DATA_LSB + DATA_W;
   localparam int RESP_TAG_LSB    = RESP_STATUS_LSB + 2;
   localparam int RESP_W          = RESP_TAG_LSB + TAG_W;

   typedef enum logic [1:0] {
      CMD_READ  = 2'b00,
      CMD_WRITE = 2'b01
   } cmd_e;

   typedef enum logic [1:0] {
      ST_OK          = 2'b00,
      ST_TIMEOUT     = 2'b01,
      ST_UNSUPPORTED = 2'b10
   } status_e;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_BUS    = 3'd2,
      S_RDWAIT = 3'd3,
      S_RESP   = 3'd4
   } state_e;

   function automatic logic [REQ_W-1:0] pack_req(
      input logic [TAG_W-1:0]  tag,
      input logic [1:0]        cmd,
      input logic [BE_W-1:0]   be,
      input logic [ADDR_W-1:0] addr,
      input logic [DATA_W-1:0] data
   );
      return {tag, cmd, be, addr, data};
   endfunction

endpackage

// File: rtl/ltpi_data_channel_target_executor.sv
// Pops request words from the target FIFO, runs each as one Avalon-MM
// transaction and pushes one response word per request, strictly in order.
module ltpi_data_channel_target_executor
   import ltpi_data_channel_target_pkg::*;
#(
   parameter int ADDR_WIDTH     = ADDR_W,
   parameter int DATA_WIDTH     = DATA_W,
   parameter int TAG_WIDTH      = TAG_W,
   parameter int TIMEOUT_CYCLES = 255,
   parameter int REQ_WIDTH      = TAG_WIDTH + 2 + DATA_WIDTH/8 + ADDR_WIDTH + DATA_WIDTH,
   parameter int RESP_WIDTH     = TAG_WIDTH + 2 + DATA_WIDTH
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [REQ_WIDTH-1:0]      req_rd_data,
   input  logic                      req_empty,
   output logic                      req_rd_req,
   output logic [RESP_WIDTH-1:0]     resp_wr_data,
   output logic                      resp_wr_req,
   input  logic                      resp_full,
   output logic [ADDR_WIDTH-1:0]     avmm_address,
   output logic                      avmm_read,
   output logic                      avmm_write,
   output logic [DATA_WIDTH-1:0]     avmm_writedata,
   output logic [DATA_WIDTH/8-1:0]   avmm_byteenable,
   input  logic                      avmm_waitrequest,
   input  logic [DATA_WIDTH-1:0]     avmm_readdata,
   input  logic                      avmm_readdatavalid,
   output logic                      busy
);

   localparam int BE_WIDTH  = DATA_WIDTH / 8;
   localparam int Q_ADDR    = DATA_WIDTH;
   localparam int Q_BE      = Q_ADDR + ADDR_WIDTH;
   localparam int Q_CMD     = Q_BE + BE_WIDTH;
   localparam int Q_TAG     = Q_CMD + 2;
   localparam int CNT_WIDTH = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

   state_e                  state_q;
   logic [TAG_WIDTH-1:0]    tag_q;
   status_e                 status_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [DATA_WIDTH-1:0]   wdata_q;
   logic [BE_WIDTH-1:0]     be_q;
   logic [DATA_WIDTH-1:0]   rdata_q;
   logic                    is_read_q;
   logic                    avmm_read_q;
   logic                    avmm_write_q;
   logic                    resp_wr_req_q;
   logic [CNT_WIDTH-1:0]    cnt_q;
   logic [1:0]              cmd_s;
   logic                    timeout_s;

   assign cmd_s     = req_rd_data[Q_CMD +: 2];
   assign timeout_s = (cnt_q >= CNT_LAST);

   // The pop is decoded straight from IDLE so the non-showahead q lands in FETCH.
   assign req_rd_req      = reset && (state_q == S_IDLE) && !req_empty;
   assign resp_wr_data    = {tag_q, status_q, rdata_q};
   assign resp_wr_req     = resp_wr_req_q;
   assign avmm_address    = addr_q;
   assign avmm_read       = avmm_read_q;
   assign avmm_write      = avmm_write_q;
   assign avmm_writedata  = wdata_q;
   assign avmm_byteenable = be_q;
   assign busy            = (state_q != S_IDLE);

   // Request sequencer: fetch, bus phase with timeout, response push.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= S_IDLE;
         tag_q         <= '0;
         status_q      <= ST_OK;
         addr_q        <= '0;
         wdata_q       <= '0;
         be_q          <= '0;
         rdata_q       <= '0;
         is_read_q     <= 1'b0;
         avmm_read_q   <= 1'b0;
         avmm_write_q  <= 1'b0;
         resp_wr_req_q <= 1'b0;
         cnt_q         <= '0;
      end else begin
         resp_wr_req_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (req_rd_req) begin
                  state_q <= S_FETCH;
               end else begin
                  state_q <= S_IDLE;
               end
            end
            S_FETCH: begin
               tag_q    <= req_rd_data[Q_TAG +: TAG_WIDTH];
               addr_q   <= req_rd_data[Q_ADDR +: ADDR_WIDTH];
               be_q     <= req_rd_data[Q_BE +: BE_WIDTH];
               wdata_q  <= req_rd_data[DATA_WIDTH-1:0];
               rdata_q  <= '0;
               cnt_q    <= '0;
               status_q <= ST_OK;
               case (cmd_s)
                  CMD_READ: begin
                     is_read_q   <= 1'b1;
                     avmm_read_q <= 1'b1;
                     state_q     <= S_BUS;
                  end
                  CMD_WRITE: begin
                     is_read_q    <= 1'b0;
                     avmm_write_q <= 1'b1;
                     state_q      <= S_BUS;
                  end
                  default: begin
                     is_read_q <= 1'b0;
                     status_q  <= ST_UNSUPPORTED;
                     state_q   <= S_RESP;
                  end
               endcase
            end
            S_BUS: begin
               cnt_q <= cnt_q + CNT_ONE;
               if (!avmm_waitrequest) begin
                  avmm_read_q  <= 1'b0;
                  avmm_write_q <= 1'b0;
                  if (!is_read_q) begin
                     state_q <= S_RESP;
                  end else if (avmm_readdatavalid) begin
                     rdata_q <= avmm_readdata;
                     state_q <= S_RESP;
                  end else begin
                     state_q <= S_RDWAIT;
                  end
               end else if (timeout_s) begin
                  avmm_read_q  <= 1'b0;
                  avmm_write_q <= 1'b0;
                  status_q     <= ST_TIMEOUT;
                  state_q      <= S_RESP;
               end else begin
                  state_q <= S_BUS;
               end
            end
            S_RDWAIT: begin
               cnt_q <= cnt_q + CNT_ONE;
               if (avmm_readdatavalid) begin
                  rdata_q <= avmm_readdata;
                  state_q <= S_RESP;
               end else if (timeout_s) begin
                  status_q <= ST_TIMEOUT;
                  state_q  <= S_RESP;
               end else begin
                  state_q <= S_RDWAIT;
               end
            end
            S_RESP: begin
               if (!resp_full) begin
                  resp_wr_req_q <= 1'b1;
                  state_q       <= S_IDLE;
               end else begin
                  state_q <= S_RESP;
               end
            end
            default: begin
               avmm_read_q  <= 1'b0;
               avmm_write_q <= 1'b0;
               state_q      <= S_IDLE;
            end
         endcase
      end
   end

endmodule
